// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor cell
// with a registered borrow; start/ready capture and valid/ack result handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  input  logic             ack
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic            br;
  logic [CW-1:0]   cnt;
  logic            d;
  logic            br_nxt;

  always_comb begin
    d      = sa[0] ^ sb[0] ^ br;
    br_nxt = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          br   <= br_nxt;
          diff <= {d, diff[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            bout  <= br_nxt;
            state <= DONE;
          end
        end
        DONE: begin
          if (ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected {bout,diff} queued at issue,
// popped and compared when valid rises.
module tb_serial_subtractor;
  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic         valid;
  logic [W-1:0] diff;
  logic         bout;
  logic         ack;

  int checks;
  int failures;
  logic [W:0] sb_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .ready(ready),
    .valid(valid),
    .diff (diff),
    .bout (bout),
    .ack  (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mbin);
    model = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
  endfunction

  // Issue at the next edge; returns with start already dropped, 1 time unit after the accept edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    @(negedge clk);
    check("ready_before_start", ready, 1);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    sb_q.push_back(model(ia, ib, ibin));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges from the accept edge until valid; checks latency and result.
  task automatic collect(input int already);
    int n;
    logic [W:0] e;
    n = already;
    while (!valid && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, W);
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("diff", diff, e[W-1:0]);
      check("bout", bout, e[W]);
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("ready_after_ack", ready, 1);
    check("valid_after_ack", valid, 0);
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    issue(ia, ib, ibin);
    collect(0);
    release_result();
  endtask

  initial begin
    logic [W:0] e;
    int seen;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; ack = 1'b0;
    a = '0; b = '0; bin = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", ready, 1);
    check("post_rst_valid", valid, 0);
    check("post_rst_diff", diff, 0);
    check("post_rst_bout", bout, 0);

    // Reset two cycles into RUN aborts with no valid afterwards
    @(negedge clk);
    a = 4'b1011; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("run_ready_low", ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_valid", valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    check("abort_no_valid", seen, 0);

    op(4'b1011, 4'b0110, 1'b1);
    op(4'b0010, 4'b1111, 1'b0);
    op(4'b0000, 4'b0000, 1'b1);
    op(4'b1111, 4'b0000, 1'b0);
    op(4'b1001, 4'b1001, 1'b0);

    // Input isolation: operands change and start pulses during RUN
    issue(4'b1110, 4'b0110, 1'b1);
    a = 4'b0000; b = 4'b1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    collect(1);
    release_result();
    seen = 0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    check("iso_single_result", seen, 0);
    check("iso_sb_empty", sb_q.size(), 0);

    // Back-pressure: hold DONE with start asserted
    issue(4'b0101, 4'b0111, 1'b0);
    e = sb_q[0];
    collect(0);
    start = 1'b1; a = 4'b1111; b = 4'b0000;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_valid", valid, 1);
      check("bp_result", {bout, diff}, e);
    end
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ack = 1'b0;
    check("bp_ack_ready", ready, 1);
    check("bp_ack_valid", valid, 0);
    @(posedge clk); #1;
    check("bp_no_new_op", ready, 1);

    for (int i = 0; i < 8; i++) begin
      op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
         1'($urandom_range(0, 1)));
    end

    check("sb_final_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor that computes diff = a - b - bin over WIDTH clock cycles, LSB first, through a single full-subtractor cell with a registered borrow.
It complements the combinational ripple adder as the sequential, inverse-arithmetic unit of the datapath library.
Operands are captured with a start/ready handshake, and the result is held under a valid/ack handshake.

Parameters:
WIDTH, 4, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only on a clk edge where ready=1
a  input  WIDTH  minuend, captured on the accepted start
b  input  WIDTH  subtrahend, captured on the accepted start
bin  input  1  borrow-in, captured on the accepted start
ready  output  1  high only in IDLE
valid  output  1  result available; high only in DONE
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH; meaningful only while valid=1
bout  output  1  borrow-out; 1 when a < b + bin (unsigned)
ack  input  1  result consumed; sampled only while valid=1

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, ready=1, valid=0, diff=0, bout=0. The bit counter, operand shift registers and the internal borrow all clear to 0.
- Reset mid-operation: asserting rst_n low in any state aborts immediately to the reset values. No partial result is ever flagged valid.
- State IDLE:
  - ready=1.
  - On an edge with start=1, capture a, b and bin into the shift registers and borrow register, clear the counter, and go to RUN.
  - start=0 stays in IDLE.
- State RUN:
  - ready=0, valid=0.
  - Each edge processes bit i (i = counter, 0..WIDTH-1):
    - d = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br)
  - Each edge shifts the operands right, shifts d into diff from the MSB end, and increments the counter.
  - After the edge that processes bit WIDTH-1, go to DONE with bout = final br_next.
- State DONE:
  - valid=1, and diff/bout are held stable.
  - On an edge with ack=1, go to IDLE (ready=1 from the next cycle). ack=0 holds DONE indefinitely.
- Latency: start is accepted at edge N. valid is first high after edge N+WIDTH and can drop no earlier than after edge N+WIDTH+1. Minimum issue interval is WIDTH+2 cycles.
- Ignored inputs:
  - start while in RUN or DONE, including start coinciding with ack, is ignored; there is no queuing.
  - ack outside DONE is ignored.
  - a, b and bin changing after capture have no effect on the result in progress.
- Arithmetic: unsigned modulo 2^WIDTH. bout is the true borrow, so {bout, diff} as a two's-complement (WIDTH+1)-bit value equals a - b - bin.
- ready and valid are decoded from the state register only; no input-to-output combinational paths.

Test Plan:
- Reset: hold rst_n=0, then release -> ready=1, valid=0, diff=0000, bout=0. Assert rst_n=0 two cycles into RUN -> ready=1, valid=0 immediately, and no valid pulse follows.
- Basic, WIDTH=4: a=1011, b=0110, bin=1, start for 1 cycle -> after exactly 4 edges valid=1, diff=0100, bout=0. ack=1 for 1 cycle -> ready=1 on the next cycle.
- Borrow-out: a=0010, b=1111, bin=0 -> diff=0011, bout=1. Then a=0000, b=0000, bin=1 -> diff=1111, bout=1.
- No borrow, full range: a=1111, b=0000, bin=0 -> diff=1111, bout=0. Then a=1001, b=1001, bin=0 -> diff=0000, bout=0.
- Input isolation: start with a=1110, b=0110, bin=1. During RUN drive a=0000, b=1111 and pulse start -> result still diff=0111, bout=0, and only one result is produced.
- Back-pressure: hold ack=0 for 10 cycles in DONE -> valid stays 1 with diff/bout stable, and start is ignored. Assert start and ack together -> DONE goes to IDLE only, with no new operation.
